// File: rtl/alu_result_buffer_8bit_if.sv
// alu_result_buffer_8bit_if: producer/consumer bus of the ALU result buffer; out_par present only with RESULT_PARITY_EN
interface alu_result_buffer_8bit_if #(parameter int AW = 2);
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_y;
  logic [2:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_y;
  logic [2:0]    out_op;
  logic          out_zero;
  logic          out_neg;
  logic [AW:0]   count;
`ifdef RESULT_PARITY_EN
  logic          out_par;
`endif
  modport master (
    output in_valid, in_y, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_op, out_zero, out_neg, count
`ifdef RESULT_PARITY_EN
    , input out_par
`endif
  );
  modport slave (
    input  in_valid, in_y, in_op, out_ready,
    output in_ready, out_valid, out_y, out_op, out_zero, out_neg, count
`ifdef RESULT_PARITY_EN
    , output out_par
`endif
  );
endinterface

// File: rtl/alu_result_buffer_8bit.sv
// alu_result_buffer_8bit: first-word-fall-through FIFO of ALU results with flags captured at push; RESULT_PARITY_EN adds stored out_par
module alu_result_buffer_8bit #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic                    clk,
  input logic                    rst,
  alu_result_buffer_8bit_if.slave bus
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [DEPTH-1:0][7:0] y_q, y_d;
  logic [DEPTH-1:0][2:0] op_q, op_d;
  logic [DEPTH-1:0]      z_q, z_d, n_q, n_d;
`ifdef RESULT_PARITY_EN
  logic [DEPTH-1:0]      p_q, p_d;
`endif
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  push, pop, full_n, head_v;
  // handshake decode, entry capture with flags, pointer/count update and masked head outputs
  always_comb begin
    full_n = cnt_q != FULL;
    head_v = cnt_q != '0;
    push   = bus.in_valid & full_n;
    pop    = head_v & bus.out_ready;
    y_d    = y_q;
    op_d   = op_q;
    z_d    = z_q;
    n_d    = n_q;
`ifdef RESULT_PARITY_EN
    p_d    = p_q;
`endif
    if (push) begin
      y_d[wr_q]  = bus.in_y;
      op_d[wr_q] = bus.in_op;
      z_d[wr_q]  = bus.in_y == 8'h00;
      n_d[wr_q]  = bus.in_y[7];
`ifdef RESULT_PARITY_EN
      p_d[wr_q]  = ^bus.in_y;
`endif
    end
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = (push & ~pop) ? cnt_q + 1'b1 : (pop & ~push) ? cnt_q - 1'b1 : cnt_q;
    bus.in_ready  = full_n;
    bus.out_valid = head_v;
    bus.count     = cnt_q;
    bus.out_y     = head_v ? y_q[rd_q] : 8'h00;
    bus.out_op    = head_v ? op_q[rd_q] : 3'd0;
    bus.out_zero  = head_v & z_q[rd_q];
    bus.out_neg   = head_v & n_q[rd_q];
`ifdef RESULT_PARITY_EN
    bus.out_par   = head_v & p_q[rd_q];
`endif
  end
  // state registers; reset discards every stored entry
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      op_q  <= '0;
      z_q   <= '0;
      n_q   <= '0;
`ifdef RESULT_PARITY_EN
      p_q   <= '0;
`endif
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      y_q   <= y_d;
      op_q  <= op_d;
      z_q   <= z_d;
      n_q   <= n_d;
`ifdef RESULT_PARITY_EN
      p_q   <= p_d;
`endif
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_result_buffer_8bit.sv
// tb_alu_result_buffer_8bit: queue-scoreboard bench with directed and random traffic for alu_result_buffer_8bit
module tb_alu_result_buffer_8bit;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  typedef struct {
    logic [7:0] y;
    logic [2:0] op;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic started = 1'b0;
  int   total = 0;
  int   bad   = 0;
  ent_t exp_q[$];
  ent_t e;
  alu_result_buffer_8bit_if #(.AW(AW)) bus();
  alu_result_buffer_8bit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask
  // record every accepted result in arrival order; reset empties the model
  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else if (bus.in_valid && bus.in_ready) exp_q.push_back('{bus.in_y, bus.in_op});
  end
  // monitor away from the edge: occupancy, handshake levels and head contents against the model
  always @(negedge clk) begin
    if (started) begin
      chk("count", int'(bus.count), exp_q.size());
      chk("in_ready", int'(bus.in_ready), int'(exp_q.size() < DEPTH));
      chk("out_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
      if (exp_q.size() == 0) begin
        chk("idle_y", int'(bus.out_y), 0);
        chk("idle_tag_flags", int'({bus.out_op, bus.out_zero, bus.out_neg}), 0);
`ifdef RESULT_PARITY_EN
        chk("idle_par", int'(bus.out_par), 0);
`endif
      end else begin
        e = exp_q[0];
        chk("out_y", int'(bus.out_y), int'(e.y));
        chk("out_op", int'(bus.out_op), int'(e.op));
        chk("out_zero", int'(bus.out_zero), int'(e.y == 8'h00));
        chk("out_neg", int'(bus.out_neg), int'($signed(e.y) < 0));
`ifdef RESULT_PARITY_EN
        chk("out_par", int'(bus.out_par), $countones(e.y) % 2);
`endif
        if (bus.out_ready && !rst) void'(exp_q.pop_front());
      end
    end
  end
  task automatic drive(input logic iv, input logic [7:0] y, input logic [2:0] op, input logic ordy);
    bus.in_valid  = iv;
    bus.in_y      = y;
    bus.in_op     = op;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_y      = 8'h00;
    bus.in_op     = 3'd0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    started = 1'b1;
    #1;
    drive(0, 8'h00, 0, 0);
    rst = 1'b0;
    drive(1, 8'h00, 3'd1, 0);
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 1);
    drive(1, 8'h80, 3'd2, 0);
    drive(1, 8'h7F, 3'd3, 0);
    drive(1, 8'h01, 3'd4, 0);
    drive(1, 8'hFF, 3'd5, 0);
    drive(1, 8'h55, 3'd6, 0);
    for (int i = 0; i < 5; i++) drive(0, 8'h00, 0, 1);
    drive(1, 8'h11, 3'd1, 0);
    drive(1, 8'h22, 3'd2, 0);
    for (int i = 0; i < 6; i++) drive(1, 8'(8'h30 + i * 8'h13), 3'(i), 1);
    drive(1, 8'hA0, 3'd7, 0);
    drive(1, 8'hA1, 3'd6, 0);
    drive(1, 8'hC3, 3'd5, 1);
    drive(1, 8'hC4, 3'd4, 1);
    for (int i = 0; i < DEPTH + 2; i++) drive(0, 8'h00, 0, 1);
    drive(1, 8'h10, 3'd1, 0);
    drive(1, 8'h20, 3'd2, 0);
    drive(1, 8'h30, 3'd3, 0);
    rst = 1'b1;
    drive(0, 8'h00, 0, 0);
    rst = 1'b0;
    drive(1, 8'h07, 3'd2, 0);
    drive(0, 8'h00, 0, 1);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), ($urandom_range(0, 2) != 0));
    end
    rst = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) drive(0, 8'h00, 0, 1);
    chk("drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
